id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register for the 5-stage MIPS datapath.
- Captures the decode-stage outputs each cycle and presents them registered to the EX stage:
  - sign-extended and zero-extended 16-bit immediates from the sign-extension unit
  - register-file read data, register specifiers, shamt, PC+4
  - decoded control bits
- Supports hazard-unit stall (hold) and flush (bubble insertion).
- Keeps a saturating count of hazard cycles for performance debug.

Parameters:
- DATA_W, 32, width of datapath words (PC+4, read data, immediates)
- REG_ADDR_W, 5, register specifier width
- ALUOP_W, 4, ALU operation code width
- CNT_W, 16, width of hazard-cycle counter

Ports:
- Clk  in  1  pipeline clock, all state on rising edge
- Reset  in  1  asynchronous, active-high reset
- Stall  in  1  hold all stage contents this cycle
- Flush  in  1  replace stage contents with a bubble this cycle
- Valid_in  in  1  decode stage holds a real instruction
- PCPlus4_in  in  DATA_W  PC+4 of decoded instruction
- ReadData1_in, ReadData2_in  in  DATA_W  register-file outputs
- ImmSExt_in  in  DATA_W  sign-extended immediate
- ImmZExt_in  in  DATA_W  zero-extended immediate
- Rs_in, Rt_in, Rd_in, Shamt_in  in  REG_ADDR_W  instruction fields
- RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in, ALUSrc_in, Branch_in, ImmZSel_in  in  1  control bits
- RegDst_in  in  2  destination select (0=Rt, 1=Rd, 2=$ra)
- ALUOp_in  in  ALUOP_W  ALU operation
- All *_out  out  same widths as the matching *_in  registered copies
- Imm_out  out  DATA_W  selected immediate: ImmZExt when ImmZSel, else ImmSExt
- Valid_out  out  1  EX stage holds a real instruction
- BranchTarget_out  out  DATA_W  precomputed branch target (optional feature)
- HazardCount  out  CNT_W  saturating count of stall and flush cycles

Behaviour:
- Clocking and reset:
  - One clock (Clk); reset is asynchronous and active-high (Reset).
  - Reset asserted forces every output to 0 immediately, independent of Clk: all *_out, Imm_out, Valid_out, BranchTarget_out, HazardCount.
  - Reset mid-stream discards the in-flight instruction. The first capture happens on the first rising edge after Reset deasserts.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
- Per-edge priority: Reset > Flush > Stall > Load.
- Load (no Stall, no Flush):
  - Every *_out takes its *_in.
  - Valid_out takes Valid_in.
  - Imm_out takes ImmZSel_in ? ImmZExt_in : ImmSExt_in. The mux sits before the register, so Imm_out has no combinational path from inputs.
- Stall (Flush=0):
  - All outputs hold their current values, including Valid_out and Imm_out.
  - HazardCount increments.
- Flush (regardless of Stall):
  - Bubble loaded: RegWrite, MemRead, MemWrite, Branch, Valid_out, ALUOp, RegDst, ALUSrc, MemToReg go to 0.
  - Data fields (PC+4, read data, immediates, specifiers, shamt) also go to 0, for deterministic traces.
  - HazardCount increments once, even if Stall is also high.
- A bubble (Valid_in=0 loaded normally) passes through unchanged. Its control bits are not forced. Downstream qualifies on Valid_out.
- HazardCount:
  - Increments by 1 on each edge where Stall or Flush is high.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by Reset.
- No combinational paths from any input to any output.

Optional Feature:
- Macro: ID_EX_BRANCH_TARGET_EN
- Defined:
  - On Load, BranchTarget_out is registered as PCPlus4_in + (ImmSExt_in << 2), truncated to DATA_W. Wrap-around modulo 2^DATA_W is normal.
  - Holds on Stall; goes to 0 on Flush and Reset.
- Undefined: BranchTarget_out is tied to 0, and no adder is synthesised.

Test Plan:
- Reset asserted asynchronously mid-cycle after loading data -> all outputs 0 before the next edge; HazardCount=0.
- Load PCPlus4=0x00400004, ImmSExt=0xFFFFFFFC, ImmZExt=0x0000FFFC, ImmZSel=0, RegWrite=1, Valid_in=1 -> next edge: Imm_out=0xFFFFFFFC, RegWrite_out=1, Valid_out=1. Repeat with ImmZSel=1 -> Imm_out=0x0000FFFC.
- Stall high 3 cycles while inputs change -> outputs frozen at the pre-stall values; HazardCount=3; on release, the current inputs load on the next edge.
- Flush and Stall both high for 1 cycle with RegWrite_in=1, MemWrite_in=1 -> RegWrite_out=0, MemWrite_out=0, Valid_out=0, data fields 0; HazardCount +1 (not +2).
- With CNT_W=4, Stall held 20 cycles -> HazardCount stops at 15 and stays 15.
- ID_EX_BRANCH_TARGET_EN defined:
  - PCPlus4=0x00400010, ImmSExt=0xFFFFFFFE -> BranchTarget_out=0x00400008.
  - PCPlus4=0xFFFFFFFC, ImmSExt=0x00000002 -> BranchTarget_out=0x00000004 (wrap).
  - Undefined -> BranchTarget_out stays 0.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
//
// ID/EX pipeline register of the 5-stage MIPS datapath. It captures the
// decode-stage outputs on every rising edge of Clk and presents them to the
// EX stage one cycle later. The hazard unit can hold the stage (Stall) or
// replace its contents with a bubble (Flush). A saturating counter records
// how many cycles were lost to hazards, for performance debug.
//
// Per-edge priority: Reset > Flush > Stall > Load.
//
// Optional feature (compile-time macro ID_EX_BRANCH_TARGET_EN):
//   defined   : BranchTarget_out = PCPlus4 + (ImmSExt << 2), registered
//               alongside the other fields.
//   undefined : BranchTarget_out is tied to zero and no adder exists.
//
// Parameters
//   DATA_W      datapath word width (PC+4, read data, immediates)
//   REG_ADDR_W  register specifier / shamt width
//   ALUOP_W     ALU operation code width
//   CNT_W       hazard-cycle counter width
//
// Ports
//   Clk               in   pipeline clock, rising edge
//   Reset             in   asynchronous, active-high reset
//   Stall             in   hold all stage contents this cycle
//   Flush             in   load a bubble this cycle
//   Valid_in          in   decode stage holds a real instruction
//   PCPlus4_in        in   PC+4 of the decoded instruction
//   ReadData1/2_in    in   register-file read data
//   ImmSExt_in        in   sign-extended immediate
//   ImmZExt_in        in   zero-extended immediate
//   Rs/Rt/Rd/Shamt_in in   instruction fields
//   RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in, ALUSrc_in,
//   Branch_in, ImmZSel_in in single-bit decoded controls
//   RegDst_in         in   destination select (0=Rt, 1=Rd, 2=$ra)
//   ALUOp_in          in   ALU operation
//   *_out             out  registered copies of the matching *_in
//   Imm_out           out  registered immediate, ZExt when ImmZSel else SExt
//   Valid_out         out  EX stage holds a real instruction
//   BranchTarget_out  out  registered branch target (optional feature)
//   HazardCount       out  saturating count of stall/flush cycles
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  Valid_in,
  input  logic [DATA_W-1:0]     PCPlus4_in,
  input  logic [DATA_W-1:0]     ReadData1_in,
  input  logic [DATA_W-1:0]     ReadData2_in,
  input  logic [DATA_W-1:0]     ImmSExt_in,
  input  logic [DATA_W-1:0]     ImmZExt_in,
  input  logic [REG_ADDR_W-1:0] Rs_in,
  input  logic [REG_ADDR_W-1:0] Rt_in,
  input  logic [REG_ADDR_W-1:0] Rd_in,
  input  logic [REG_ADDR_W-1:0] Shamt_in,
  input  logic                  RegWrite_in,
  input  logic                  MemRead_in,
  input  logic                  MemWrite_in,
  input  logic                  MemToReg_in,
  input  logic                  ALUSrc_in,
  input  logic                  Branch_in,
  input  logic                  ImmZSel_in,
  input  logic [1:0]            RegDst_in,
  input  logic [ALUOP_W-1:0]    ALUOp_in,
  output logic                  Valid_out,
  output logic [DATA_W-1:0]     PCPlus4_out,
  output logic [DATA_W-1:0]     ReadData1_out,
  output logic [DATA_W-1:0]     ReadData2_out,
  output logic [DATA_W-1:0]     ImmSExt_out,
  output logic [DATA_W-1:0]     ImmZExt_out,
  output logic [REG_ADDR_W-1:0] Rs_out,
  output logic [REG_ADDR_W-1:0] Rt_out,
  output logic [REG_ADDR_W-1:0] Rd_out,
  output logic [REG_ADDR_W-1:0] Shamt_out,
  output logic                  RegWrite_out,
  output logic                  MemRead_out,
  output logic                  MemWrite_out,
  output logic                  MemToReg_out,
  output logic                  ALUSrc_out,
  output logic                  Branch_out,
  output logic                  ImmZSel_out,
  output logic [1:0]            RegDst_out,
  output logic [ALUOP_W-1:0]    ALUOp_out,
  output logic [DATA_W-1:0]     Imm_out,
  output logic [DATA_W-1:0]     BranchTarget_out,
  output logic [CNT_W-1:0]      HazardCount
);

  // Immediate select happens ahead of the register so Imm_out is a pure
  // flop output and EX sees no mux delay.
  logic [DATA_W-1:0] imm_sel;
  assign imm_sel = ImmZSel_in ? ImmZExt_in : ImmSExt_in;

  logic load_en;
  assign load_en = !Flush && !Stall;

  // Data fields: flushed to zero as well so pipeline traces stay clean.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      PCPlus4_out   <= '0;
      ReadData1_out <= '0;
      ReadData2_out <= '0;
      ImmSExt_out   <= '0;
      ImmZExt_out   <= '0;
      Imm_out       <= '0;
      Rs_out        <= '0;
      Rt_out        <= '0;
      Rd_out        <= '0;
      Shamt_out     <= '0;
    end else if (Flush) begin
      PCPlus4_out   <= '0;
      ReadData1_out <= '0;
      ReadData2_out <= '0;
      ImmSExt_out   <= '0;
      ImmZExt_out   <= '0;
      Imm_out       <= '0;
      Rs_out        <= '0;
      Rt_out        <= '0;
      Rd_out        <= '0;
      Shamt_out     <= '0;
    end else if (load_en) begin
      PCPlus4_out   <= PCPlus4_in;
      ReadData1_out <= ReadData1_in;
      ReadData2_out <= ReadData2_in;
      ImmSExt_out   <= ImmSExt_in;
      ImmZExt_out   <= ImmZExt_in;
      Imm_out       <= imm_sel;
      Rs_out        <= Rs_in;
      Rt_out        <= Rt_in;
      Rd_out        <= Rd_in;
      Shamt_out     <= Shamt_in;
    end
  end

  // Control fields. A normally loaded bubble (Valid_in=0) keeps whatever
  // control bits decode produced; only Flush forces them to zero. EX and
  // later stages qualify on Valid_out.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Valid_out    <= 1'b0;
      RegWrite_out <= 1'b0;
      MemRead_out  <= 1'b0;
      MemWrite_out <= 1'b0;
      MemToReg_out <= 1'b0;
      ALUSrc_out   <= 1'b0;
      Branch_out   <= 1'b0;
      ImmZSel_out  <= 1'b0;
      RegDst_out   <= '0;
      ALUOp_out    <= '0;
    end else if (Flush) begin
      Valid_out    <= 1'b0;
      RegWrite_out <= 1'b0;
      MemRead_out  <= 1'b0;
      MemWrite_out <= 1'b0;
      MemToReg_out <= 1'b0;
      ALUSrc_out   <= 1'b0;
      Branch_out   <= 1'b0;
      ImmZSel_out  <= 1'b0;
      RegDst_out   <= '0;
      ALUOp_out    <= '0;
    end else if (load_en) begin
      Valid_out    <= Valid_in;
      RegWrite_out <= RegWrite_in;
      MemRead_out  <= MemRead_in;
      MemWrite_out <= MemWrite_in;
      MemToReg_out <= MemToReg_in;
      ALUSrc_out   <= ALUSrc_in;
      Branch_out   <= Branch_in;
      ImmZSel_out  <= ImmZSel_in;
      RegDst_out   <= RegDst_in;
      ALUOp_out    <= ALUOp_in;
    end
  end

  // Hazard-cycle counter: one count per edge with Stall or Flush (a
  // simultaneous Stall+Flush is still one lost cycle). Sticks at all-ones.
  logic hazard_cycle;
  logic cnt_at_max;
  assign hazard_cycle = Stall || Flush;
  assign cnt_at_max   = (HazardCount == {CNT_W{1'b1}});

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      HazardCount <= '0;
    end else if (hazard_cycle && !cnt_at_max) begin
      HazardCount <= HazardCount + CNT_W'(1);
    end
  end

`ifdef ID_EX_BRANCH_TARGET_EN
  // Word offset shifted left by two, added to PC+4; overflow wraps.
  logic [DATA_W-1:0] branch_target;
  assign branch_target = PCPlus4_in + (ImmSExt_in << 2);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      BranchTarget_out <= '0;
    end else if (Flush) begin
      BranchTarget_out <= '0;
    end else if (load_en) begin
      BranchTarget_out <= branch_target;
    end
  end
`else
  assign BranchTarget_out = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int OW = 4;

  logic Clk = 1'b0;
  logic Reset, Stall, Flush, Valid_in;
  logic [DW-1:0] PCPlus4_in, ReadData1_in, ReadData2_in, ImmSExt_in, ImmZExt_in;
  logic [AW-1:0] Rs_in, Rt_in, Rd_in, Shamt_in;
  logic RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in, ALUSrc_in, Branch_in, ImmZSel_in;
  logic [1:0] RegDst_in;
  logic [OW-1:0] ALUOp_in;

  logic Valid_out;
  logic [DW-1:0] PCPlus4_out, ReadData1_out, ReadData2_out, ImmSExt_out, ImmZExt_out, Imm_out, BranchTarget_out;
  logic [AW-1:0] Rs_out, Rt_out, Rd_out, Shamt_out;
  logic RegWrite_out, MemRead_out, MemWrite_out, MemToReg_out, ALUSrc_out, Branch_out, ImmZSel_out;
  logic [1:0] RegDst_out;
  logic [OW-1:0] ALUOp_out;
  logic [15:0] HazardCount;

  // second instance with a 4-bit counter, for the saturation boundary
  logic s_valid;
  logic [DW-1:0] s_pc, s_rd1, s_rd2, s_sext, s_zext, s_imm, s_bt;
  logic [AW-1:0] s_rs, s_rt, s_rd, s_shamt;
  logic s_rw, s_mr, s_mw, s_m2r, s_as, s_br, s_zs;
  logic [1:0] s_dst;
  logic [OW-1:0] s_aluop;
  logic [3:0] s_cnt;

  always #5 Clk = ~Clk;

  id_ex_stage_reg dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .Valid_in(Valid_in),
    .PCPlus4_in(PCPlus4_in), .ReadData1_in(ReadData1_in), .ReadData2_in(ReadData2_in),
    .ImmSExt_in(ImmSExt_in), .ImmZExt_in(ImmZExt_in),
    .Rs_in(Rs_in), .Rt_in(Rt_in), .Rd_in(Rd_in), .Shamt_in(Shamt_in),
    .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .MemToReg_in(MemToReg_in), .ALUSrc_in(ALUSrc_in), .Branch_in(Branch_in),
    .ImmZSel_in(ImmZSel_in), .RegDst_in(RegDst_in), .ALUOp_in(ALUOp_in),
    .Valid_out(Valid_out), .PCPlus4_out(PCPlus4_out), .ReadData1_out(ReadData1_out),
    .ReadData2_out(ReadData2_out), .ImmSExt_out(ImmSExt_out), .ImmZExt_out(ImmZExt_out),
    .Rs_out(Rs_out), .Rt_out(Rt_out), .Rd_out(Rd_out), .Shamt_out(Shamt_out),
    .RegWrite_out(RegWrite_out), .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
    .MemToReg_out(MemToReg_out), .ALUSrc_out(ALUSrc_out), .Branch_out(Branch_out),
    .ImmZSel_out(ImmZSel_out), .RegDst_out(RegDst_out), .ALUOp_out(ALUOp_out),
    .Imm_out(Imm_out), .BranchTarget_out(BranchTarget_out), .HazardCount(HazardCount)
  );

  id_ex_stage_reg #(.CNT_W(4)) dut_sat (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .Valid_in(Valid_in),
    .PCPlus4_in(PCPlus4_in), .ReadData1_in(ReadData1_in), .ReadData2_in(ReadData2_in),
    .ImmSExt_in(ImmSExt_in), .ImmZExt_in(ImmZExt_in),
    .Rs_in(Rs_in), .Rt_in(Rt_in), .Rd_in(Rd_in), .Shamt_in(Shamt_in),
    .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .MemToReg_in(MemToReg_in), .ALUSrc_in(ALUSrc_in), .Branch_in(Branch_in),
    .ImmZSel_in(ImmZSel_in), .RegDst_in(RegDst_in), .ALUOp_in(ALUOp_in),
    .Valid_out(s_valid), .PCPlus4_out(s_pc), .ReadData1_out(s_rd1),
    .ReadData2_out(s_rd2), .ImmSExt_out(s_sext), .ImmZExt_out(s_zext),
    .Rs_out(s_rs), .Rt_out(s_rt), .Rd_out(s_rd), .Shamt_out(s_shamt),
    .RegWrite_out(s_rw), .MemRead_out(s_mr), .MemWrite_out(s_mw),
    .MemToReg_out(s_m2r), .ALUSrc_out(s_as), .Branch_out(s_br),
    .ImmZSel_out(s_zs), .RegDst_out(s_dst), .ALUOp_out(s_aluop),
    .Imm_out(s_imm), .BranchTarget_out(s_bt), .HazardCount(s_cnt)
  );

  // ---------------- reference model: one record per stage content ------------
  typedef struct {
    bit        valid;
    bit [31:0] pc, rd1, rd2, sext, zext, imm, bt;
    bit [4:0]  rs, rt, rd, shamt;
    bit        rw, mr, mw, m2r, as, br, zs;
    bit [1:0]  dst;
    bit [3:0]  aluop;
  } stage_t;

  stage_t m;
  int     m_cnt, m_cnt4;
  int     n_vec = 0;
  int     n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic stage_t empty_stage();
    stage_t s;
    s = '{default: 0};
    return s;
  endfunction

  task automatic model_reset();
    m = empty_stage();
    m_cnt = 0;
    m_cnt4 = 0;
  endtask

  // the instruction the decode stage currently offers
  function automatic stage_t offered();
    stage_t s;
    s.valid = Valid_in;
    s.pc = PCPlus4_in; s.rd1 = ReadData1_in; s.rd2 = ReadData2_in;
    s.sext = ImmSExt_in; s.zext = ImmZExt_in;
    s.imm = ImmZSel_in ? ImmZExt_in : ImmSExt_in;
`ifdef ID_EX_BRANCH_TARGET_EN
    s.bt = 32'((64'(PCPlus4_in) + 64'(ImmSExt_in) * 4) % 64'h1_0000_0000);
`else
    s.bt = 0;
`endif
    s.rs = Rs_in; s.rt = Rt_in; s.rd = Rd_in; s.shamt = Shamt_in;
    s.rw = RegWrite_in; s.mr = MemRead_in; s.mw = MemWrite_in; s.m2r = MemToReg_in;
    s.as = ALUSrc_in; s.br = Branch_in; s.zs = ImmZSel_in;
    s.dst = RegDst_in; s.aluop = ALUOp_in;
    return s;
  endfunction

  task automatic model_edge();
    if (Flush)       m = empty_stage();
    else if (!Stall) m = offered();
    if (Stall || Flush) begin
      m_cnt  = (m_cnt  >= 65535) ? 65535 : m_cnt + 1;
      m_cnt4 = (m_cnt4 >= 15)    ? 15    : m_cnt4 + 1;
    end
  endtask

  task automatic check_all();
    chk("valid", Valid_out, m.valid);
    chk("pc4", PCPlus4_out, m.pc);
    chk("rd1", ReadData1_out, m.rd1);
    chk("rd2", ReadData2_out, m.rd2);
    chk("sext", ImmSExt_out, m.sext);
    chk("zext", ImmZExt_out, m.zext);
    chk("imm", Imm_out, m.imm);
    chk("btgt", BranchTarget_out, m.bt);
    chk("rs", Rs_out, m.rs);
    chk("rt", Rt_out, m.rt);
    chk("rd", Rd_out, m.rd);
    chk("shamt", Shamt_out, m.shamt);
    chk("regwrite", RegWrite_out, m.rw);
    chk("memread", MemRead_out, m.mr);
    chk("memwrite", MemWrite_out, m.mw);
    chk("memtoreg", MemToReg_out, m.m2r);
    chk("alusrc", ALUSrc_out, m.as);
    chk("branch", Branch_out, m.br);
    chk("immzsel", ImmZSel_out, m.zs);
    chk("regdst", RegDst_out, m.dst);
    chk("aluop", ALUOp_out, m.aluop);
    chk("hazcnt", HazardCount, m_cnt);
    chk("hazcnt4", s_cnt, m_cnt4);
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    check_all();
  endtask

  task automatic rand_data();
    Valid_in = 1'($urandom_range(0, 1));
    PCPlus4_in = $urandom; ReadData1_in = $urandom; ReadData2_in = $urandom;
    ImmSExt_in = $urandom; ImmZExt_in = $urandom;
    Rs_in = 5'($urandom); Rt_in = 5'($urandom); Rd_in = 5'($urandom); Shamt_in = 5'($urandom);
    RegWrite_in = 1'($urandom); MemRead_in = 1'($urandom); MemWrite_in = 1'($urandom);
    MemToReg_in = 1'($urandom); ALUSrc_in = 1'($urandom); Branch_in = 1'($urandom);
    ImmZSel_in = 1'($urandom);
    RegDst_in = 2'($urandom_range(0, 2));
    ALUOp_in = 4'($urandom);
  endtask

  // asynchronous reset pulse placed between edges (called at a negedge)
  task automatic mid_cycle_reset();
    #2 Reset = 1'b1;
    #1 model_reset();
    check_all();
    #1 Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
    rand_data();
    model_reset();
    repeat (2) @(negedge Clk);
    check_all();
    Reset = 1'b0;

    // load with sign-extended then zero-extended immediate
    rand_data();
    PCPlus4_in = 32'h0040_0004; ImmSExt_in = 32'hFFFF_FFFC; ImmZExt_in = 32'h0000_FFFC;
    ImmZSel_in = 1'b0; RegWrite_in = 1'b1; Valid_in = 1'b1;
    step();
    chk("dir_imm_s", Imm_out, 32'hFFFF_FFFC);
    chk("dir_rw", RegWrite_out, 1'b1);
    chk("dir_valid", Valid_out, 1'b1);
    ImmZSel_in = 1'b1;
    step();
    chk("dir_imm_z", Imm_out, 32'h0000_FFFC);

    // asynchronous reset with data loaded
    mid_cycle_reset();
    chk("dir_rst_cnt", HazardCount, 16'd0);
    chk("dir_rst_pc", PCPlus4_out, 32'd0);

    // stall for three cycles while inputs keep changing
    rand_data();
    step();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      step();
    end
    chk("dir_stall_cnt", HazardCount, 16'd3);
    Stall = 1'b0;
    rand_data();
    step();
    chk("dir_release_pc", PCPlus4_out, PCPlus4_in);

    // flush and stall together
    RegWrite_in = 1'b1; MemWrite_in = 1'b1; Valid_in = 1'b1;
    Stall = 1'b1; Flush = 1'b1;
    step();
    chk("dir_fl_rw", RegWrite_out, 1'b0);
    chk("dir_fl_mw", MemWrite_out, 1'b0);
    chk("dir_fl_valid", Valid_out, 1'b0);
    chk("dir_fl_rd1", ReadData1_out, 32'd0);
    chk("dir_fl_cnt", HazardCount, 16'd4);
    Flush = 1'b0;

    // long stall: 4-bit counter saturates
    for (int i = 0; i < 20; i++) begin
      rand_data();
      step();
    end
    chk("dir_sat4", s_cnt, 4'd15);
    chk("dir_cnt16", HazardCount, 16'd24);
    Stall = 1'b0;

    // branch target, including wrap-around
    rand_data();
    PCPlus4_in = 32'h0040_0010; ImmSExt_in = 32'hFFFF_FFFE;
    step();
`ifdef ID_EX_BRANCH_TARGET_EN
    chk("dir_bt", BranchTarget_out, 32'h0040_0008);
`else
    chk("dir_bt_off", BranchTarget_out, 32'd0);
`endif
    PCPlus4_in = 32'hFFFF_FFFC; ImmSExt_in = 32'h0000_0002;
    step();
`ifdef ID_EX_BRANCH_TARGET_EN
    chk("dir_bt_wrap", BranchTarget_out, 32'h0000_0004);
`else
    chk("dir_bt_off2", BranchTarget_out, 32'd0);
`endif

    // randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 400; i++) begin
      rand_data();
      Stall = ($urandom_range(0, 3) == 0);
      Flush = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 59) == 0) mid_cycle_reset();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
